// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read lanes, two write ports (port 1 wins on conflict).
// Define REGFILE_BYPASS_EN to forward same-edge write data to reads of the same address.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Writes to register 0 are dropped when it is hardwired to zero.
  logic wr_ok0;
  logic wr_ok1;
  logic wr0_lost;

  assign wr_ok0   = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr_ok1   = we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  assign wr0_lost = wr_ok1 && (waddr1 == waddr0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_ok0 && !wr0_lost) begin
        regs[waddr0] <= wdata0;
      end
      if (wr_ok1) begin
        regs[waddr1] <= wdata1;
      end
    end
  end

  // Read contract: rd_en[k] high on an edge loads lane k with the addressed
  // register; the lane is valid from the following cycle and holds while rd_en[k] is low.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rval;
    logic [DATA_W-1:0] lane_q;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rval = regs[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok0 && (waddr0 == ra)) begin
        rval = wdata0;
      end
      if (wr_ok1 && (waddr1 == ra)) begin
        rval = wdata1;
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rval = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
      end else if (rd_en[k]) begin
        lane_q <= rval;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = lane_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share stimulus;
// an array-based reference model predicts every rd_data vector into a scoreboard queue.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int DEPTH = 32;
  localparam int W     = 2 * NR * DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NR-1:0]      rd_en;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data_z;
  logic [NR*DW-1:0]   rd_data_n;
  logic               we0;
  logic [AW-1:0]      waddr0;
  logic [DW-1:0]      wdata0;
  logic               we1;
  logic [AW-1:0]      waddr1;
  logic [DW-1:0]      wdata1;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1)
  );

  // reference model: index 0 = zero-register instance, 1 = plain instance
  logic [DW-1:0] mem  [2][DEPTH];
  logic [DW-1:0] lane [2][NR];
  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad   = 0;

  task automatic model_step();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    logic [W-1:0]  vec;
    bit            zero;
    for (int m = 0; m < 2; m++) begin
      zero = (m == 0);
      for (int k = 0; k < NR; k++) begin
        a = rd_addr[k*AW +: AW];
        if (rst) begin
          lane[m][k] = '0;
        end else if (rd_en[k]) begin
          if (zero && a == 0) begin
            v = '0;
          end else begin
            v = mem[m][a];
`ifdef REGFILE_BYPASS_EN
            if (we1 && waddr1 == a) v = wdata1;
            else if (we0 && waddr0 == a) v = wdata0;
`endif
          end
          lane[m][k] = v;
        end
      end
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[m][i] = '0;
      end else begin
        // port 1 applied last so it wins a same-address conflict
        if (we0 && !(zero && waddr0 == 0)) mem[m][waddr0] = wdata0;
        if (we1 && !(zero && waddr1 == 0)) mem[m][waddr1] = wdata1;
      end
    end
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < NR; k++)
        vec[(m*NR + k)*DW +: DW] = lane[m][k];
    exp_q.push_back(vec);
  endtask

  // driver tasks
  task automatic set_idle();
    rst = 1'b0; rd_en = '0; rd_addr = '0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic rd(input int k, input int a);
    rd_en[k] = 1'b1;
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic wr0(input int a, input logic [DW-1:0] d);
    we0 = 1'b1; waddr0 = AW'(a); wdata0 = d;
  endtask

  task automatic wr1(input int a, input logic [DW-1:0] d);
    we1 = 1'b1; waddr1 = AW'(a); wdata1 = d;
  endtask

  // scoreboard monitor: one expected vector per clock edge
  logic [W-1:0] e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd_data_z !== e[NR*DW-1:0]) begin
        bad++;
        $display("FAIL rd_data_zero_reg t=%0t got=%h exp=%h", $time, rd_data_z, e[NR*DW-1:0]);
      end
      total++;
      if (rd_data_n !== e[W-1:NR*DW]) begin
        bad++;
        $display("FAIL rd_data_plain t=%0t got=%h exp=%h", $time, rd_data_n, e[W-1:NR*DW]);
      end
    end
  end

  initial begin
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    // reset clear
    set_idle(); wr0(5, 32'hDEADBEEF); tick();
    set_idle(); rst = 1'b1; rd(0, 5); tick();
    set_idle(); rd(0, 5); tick();
    set_idle(); tick();
    // basic write/read
    set_idle(); wr0(8, 32'h0000000A); tick();
    set_idle(); rd(0, 8); rd(1, 8); tick();
    // dual-write conflict
    set_idle(); wr0(9, 32'h11111111); wr1(9, 32'h22222222); tick();
    set_idle(); rd(0, 9); rd(1, 9); rd(2, 9); tick();
    // zero register
    set_idle(); wr1(0, 32'hFFFFFFFF); tick();
    set_idle(); rd(0, 0); rd(2, 0); tick();
    // same-edge read-after-write
    set_idle(); wr0(17, 32'h00000003); tick();
    set_idle(); wr0(17, 32'h00000040); rd(0, 17); tick();
    set_idle(); rd(0, 17); tick();
    // same-edge write to r0 with bypass candidate
    set_idle(); wr0(0, 32'h12345678); rd(1, 0); tick();
    // hold
    set_idle(); wr0(18, 32'h0000000A); tick();
    set_idle(); rd(2, 18); tick();
    set_idle(); wr0(18, 32'h0000000B); tick();
    set_idle(); tick();
    set_idle(); tick();
    set_idle(); rd(2, 18); tick();
    // reset held several cycles with activity
    set_idle(); rst = 1'b1; rd_en = '1; wr0(3, 32'h5); wr1(4, 32'h6); tick();
    tick();
    set_idle(); rd(0, 3); rd(1, 4); tick();

    // randomized phase
    for (int n = 0; n < 2000; n++) begin
      set_idle();
      rst   = ($urandom_range(0, 63) == 0);
      rd_en = NR'($urandom);
      for (int k = 0; k < NR; k++) begin
        rd_addr[k*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                                          : AW'($urandom_range(0, DEPTH-1));
      end
      we0    = ($urandom_range(0, 2) != 0);
      waddr0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH-1));
      wdata0 = $urandom;
      we1    = ($urandom_range(0, 2) != 0);
      waddr1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH-1));
      wdata1 = $urandom;
      tick();
    end

    set_idle();
    for (int k = 0; k < NR; k++) rd(k, k + 1);
    tick();
    set_idle();
    tick();
    @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
